// File: rtl/maple_rx_decoders.sv
// rtl/maple_rx_decoders.sv - Maple bus receive start/end pattern detectors and byte assembler.
// Consumes synchronised SDCKA/SDCKB levels and edge strobes; all outputs are registered.
module maple_rx_decoders #(
  parameter int START_NORMAL = 4,
  parameter int START_CRC    = 6,
  parameter int START_OCC    = 8,
  parameter int START_RST    = 14,
  parameter int END_PULSES   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame,
  input  logic       sdcka_data,
  input  logic       sdcka_posedge,
  input  logic       sdcka_negedge,
  input  logic       sdckb_data,
  input  logic       sdckb_posedge,
  input  logic       sdckb_negedge,
  output logic       start_frame,
  output logic       start_with_crc,
  output logic       start_occupancy,
  output logic       start_reset,
  output logic       start_frame_error,
  output logic       end_frame,
  output logic       end_frame_error,
  output logic [7:0] data,
  output logic       data_ready
);

  typedef enum logic {IDLE, COUNT} det_state_t;

  localparam logic [3:0] CNT_NORMAL = 4'(START_NORMAL);
  localparam logic [3:0] CNT_CRC    = 4'(START_CRC);
  localparam logic [3:0] CNT_OCC    = 4'(START_OCC);
  localparam logic [3:0] CNT_RST    = 4'(START_RST);
  localparam logic [3:0] CNT_END    = 4'(END_PULSES);

  // Any A strobe coinciding with any B strobe cannot be a legal line transition.
  logic glitch;
  assign glitch = (sdcka_posedge | sdcka_negedge) & (sdckb_posedge | sdckb_negedge);

  det_state_t st_state;
  logic [3:0] st_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_state          <= IDLE;
      st_count          <= 4'd0;
      start_frame       <= 1'b0;
      start_with_crc    <= 1'b0;
      start_occupancy   <= 1'b0;
      start_reset       <= 1'b0;
      start_frame_error <= 1'b0;
    end else begin
      start_frame       <= 1'b0;
      start_with_crc    <= 1'b0;
      start_occupancy   <= 1'b0;
      start_reset       <= 1'b0;
      start_frame_error <= 1'b0;
      case (st_state)
        IDLE: begin
          if (!glitch && sdcka_negedge && sdckb_data) begin
            st_state <= COUNT;
            st_count <= 4'd0;
          end
        end
        COUNT: begin
          if (glitch) begin
            st_state <= IDLE;
          end else if (sdcka_posedge) begin
            st_state <= IDLE;
            if (st_count == CNT_NORMAL)   start_frame     <= 1'b1;
            else if (st_count == CNT_CRC) start_with_crc  <= 1'b1;
            else if (st_count == CNT_OCC) start_occupancy <= 1'b1;
            else if (st_count == CNT_RST) start_reset     <= 1'b1;
            else if (st_count > 4'd1)     start_frame_error <= 1'b1;
          end else if (sdckb_negedge && st_count != 4'hF) begin
            st_count <= st_count + 4'd1;
          end
        end
        default: st_state <= IDLE;
      endcase
    end
  end

  det_state_t en_state;
  logic [3:0] en_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_state        <= IDLE;
      en_count        <= 4'd0;
      end_frame       <= 1'b0;
      end_frame_error <= 1'b0;
    end else begin
      end_frame       <= 1'b0;
      end_frame_error <= 1'b0;
      case (en_state)
        IDLE: begin
          if (!glitch && sdckb_negedge && sdcka_data) begin
            en_state <= COUNT;
            en_count <= 4'd0;
          end
        end
        COUNT: begin
          if (glitch) begin
            en_state <= IDLE;
          end else if (sdckb_posedge) begin
            en_state <= IDLE;
            if (en_count == CNT_END)  end_frame       <= 1'b1;
            else if (en_count > 4'd1) end_frame_error <= 1'b1;
          end else if (sdcka_negedge && en_count != 4'hF) begin
            en_count <= en_count + 4'd1;
          end
        end
        default: en_state <= IDLE;
      endcase
    end
  end

  // Even bits clock on SDCKA falls (value on SDCKB), odd bits the other way round.
  logic [2:0] bit_idx;
  logic [6:0] shift;
  logic       bit_take;
  logic       bit_val;

  assign bit_take = frame && !glitch &&
                    ((!bit_idx[0] && sdcka_negedge) || (bit_idx[0] && sdckb_negedge));
  assign bit_val  = bit_idx[0] ? sdcka_data : sdckb_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_idx    <= 3'd0;
      shift      <= 7'd0;
      data       <= 8'h00;
      data_ready <= 1'b0;
    end else begin
      data_ready <= 1'b0;
      if (!frame) begin
        bit_idx <= 3'd0;
      end else if (bit_take) begin
        shift <= {shift[5:0], bit_val};
        if (bit_idx == 3'd7) begin
          data       <= {shift, bit_val};
          data_ready <= 1'b1;
          bit_idx    <= 3'd0;
        end else begin
          bit_idx <= bit_idx + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_maple_rx_decoders.sv
// tb/tb_maple_rx_decoders.sv - Self-checking bench for maple_rx_decoders.
// Line levels are driven per clock; edge strobes are derived from level changes.
module tb_maple_rx_decoders;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       frame = 1'b0;
  logic       sdcka_data = 1'b1, sdcka_posedge = 1'b0, sdcka_negedge = 1'b0;
  logic       sdckb_data = 1'b1, sdckb_posedge = 1'b0, sdckb_negedge = 1'b0;
  logic       start_frame, start_with_crc, start_occupancy, start_reset, start_frame_error;
  logic       end_frame, end_frame_error, data_ready;
  logic [7:0] data;

  int checks = 0;
  int errors = 0;
  int cnt[8];

  maple_rx_decoders dut (
    .clk(clk), .reset(reset), .frame(frame),
    .sdcka_data(sdcka_data), .sdcka_posedge(sdcka_posedge), .sdcka_negedge(sdcka_negedge),
    .sdckb_data(sdckb_data), .sdckb_posedge(sdckb_posedge), .sdckb_negedge(sdckb_negedge),
    .start_frame(start_frame), .start_with_crc(start_with_crc),
    .start_occupancy(start_occupancy), .start_reset(start_reset),
    .start_frame_error(start_frame_error), .end_frame(end_frame),
    .end_frame_error(end_frame_error), .data(data), .data_ready(data_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] start_vec();
    return {start_frame, start_with_crc, start_occupancy, start_reset, start_frame_error};
  endfunction

  function automatic logic [15:0] all_outs();
    return {start_vec(), end_frame, end_frame_error, data_ready, data};
  endfunction

  // Start outputs as {frame, crc, occupancy, reset, error} for n SDCKB falls.
  function automatic logic [4:0] exp_start(input int n);
    int c;
    c = (n > 15) ? 15 : n;
    if (c == 4)       return 5'b10000;
    else if (c == 6)  return 5'b01000;
    else if (c == 8)  return 5'b00100;
    else if (c == 14) return 5'b00010;
    else if (c < 2)   return 5'b00000;
    else              return 5'b00001;
  endfunction

  function automatic logic [1:0] exp_end(input int n);
    if (n == 2)     return 2'b10;
    else if (n < 2) return 2'b00;
    else            return 2'b01;
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    foreach (cnt[i]) cnt[i] = 0;
  endtask

  // One clock with the given line levels; samples outputs just after the edge.
  task automatic drive(input logic a, input logic b);
    sdcka_posedge = a & ~sdcka_data;
    sdcka_negedge = ~a & sdcka_data;
    sdckb_posedge = b & ~sdckb_data;
    sdckb_negedge = ~b & sdckb_data;
    sdcka_data = a;
    sdckb_data = b;
    @(posedge clk);
    #1;
    cnt[0] += int'(start_frame);
    cnt[1] += int'(start_with_crc);
    cnt[2] += int'(start_occupancy);
    cnt[3] += int'(start_reset);
    cnt[4] += int'(start_frame_error);
    cnt[5] += int'(end_frame);
    cnt[6] += int'(end_frame_error);
    cnt[7] += int'(data_ready);
  endtask

  task automatic run_start(input int n, input bit glitch_end);
    logic [4:0] imm, exp;
    clear_counts();
    drive(1, 1);
    drive(0, 1);
    for (int i = 0; i < n; i++) begin
      drive(0, 0);
      drive(0, 1);
    end
    if (glitch_end) begin
      drive(1, 0);
      imm = start_vec();
      drive(1, 1);
      exp = 5'b00000;
    end else begin
      drive(1, 1);
      imm = start_vec();
      exp = exp_start(n);
    end
    drive(1, 1);
    drive(1, 1);
    check($sformatf("start_pulse n=%0d g=%0d", n, glitch_end), int'(imm), int'(exp));
    check($sformatf("start_count n=%0d", n), cnt[0] + cnt[1] + cnt[2] + cnt[3] + cnt[4],
          int'($countones(exp)));
    check($sformatf("start_no_end n=%0d", n), cnt[5] + cnt[6] + cnt[7], 0);
  endtask

  task automatic run_end(input int n);
    logic [1:0] imm;
    clear_counts();
    drive(1, 1);
    drive(1, 0);
    for (int i = 0; i < n; i++) begin
      drive(0, 0);
      drive(1, 0);
    end
    drive(1, 1);
    imm = {end_frame, end_frame_error};
    drive(1, 1);
    drive(1, 1);
    check($sformatf("end_pulse n=%0d", n), int'(imm), int'(exp_end(n)));
    check($sformatf("end_count n=%0d", n), cnt[5] + cnt[6], int'($countones(exp_end(n))));
    check($sformatf("end_no_start n=%0d", n), cnt[0] + cnt[1] + cnt[2] + cnt[3] + cnt[4], 0);
  endtask

  task automatic send_bits(input logic [7:0] v, input int nb);
    logic b;
    for (int i = 0; i < nb; i++) begin
      b = v[7-i];
      if (i % 2 == 0) begin
        drive(sdcka_data, b);
        drive(1, b);
        drive(0, b);
      end else begin
        drive(b, sdckb_data);
        drive(b, 1);
        drive(b, 0);
      end
    end
  endtask

  task automatic send_byte_check(input logic [7:0] v, input int exp_ready);
    clear_counts();
    send_bits(v, 8);
    check($sformatf("byte_ready_imm %02h", v), int'(data_ready), 1);
    check($sformatf("byte_data %02h", v), int'(data), int'(v));
    drive(sdcka_data, sdckb_data);
    check($sformatf("byte_ready_count %02h", v), cnt[7], exp_ready);
    check($sformatf("byte_hold %02h", v), int'(data), int'(v));
  endtask

  task automatic async_reset_check(input string tag);
    #2 reset = 1'b0;
    #1 check(tag, int'(all_outs()), 0);
    sdcka_posedge = 0; sdcka_negedge = 0; sdckb_posedge = 0; sdckb_negedge = 0;
    sdcka_data = 1; sdckb_data = 1; frame = 0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic [7:0] prev;
    logic [7:0] rb;
    #12 check("reset_outputs", int'(all_outs()), 0);
    @(negedge clk);
    reset = 1'b1;

    run_start(4, 0);
    run_start(6, 0);
    run_start(8, 0);
    run_start(14, 0);
    run_start(5, 0);
    run_start(1, 0);
    run_start(0, 0);
    run_start(17, 0);
    run_start(4, 1);
    run_end(2);
    run_end(3);
    run_end(1);
    run_end(16);
    for (int k = 0; k < 12; k++) run_start(int'($urandom_range(0, 17)), 0);
    for (int k = 0; k < 12; k++) run_end(int'($urandom_range(0, 17)));

    frame = 1;
    drive(sdcka_data, 1);
    drive(sdcka_data, 0);
    send_byte_check(8'hA5, 1);

    clear_counts();
    send_bits(8'hF0, 4);
    frame = 0;
    drive(sdcka_data, sdckb_data);
    frame = 1;
    check("partial_no_ready", cnt[7], 0);
    check("partial_data_hold", int'(data), 8'hA5);
    send_byte_check(8'h3C, 1);

    for (int k = 0; k < 8; k++) begin
      rb = 8'($urandom);
      send_byte_check(rb, 1);
    end
    frame = 0;

    drive(1, 1);
    drive(0, 1);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0);
      drive(0, 1);
    end
    async_reset_check("reset_mid_start");
    run_start(4, 0);

    frame = 1;
    send_byte_check(8'hC3, 1);
    prev = data;
    send_bits(8'hFF, 3);
    check("pre_reset_data", int'(data), int'(prev));
    async_reset_check("reset_mid_byte");
    frame = 1;
    send_byte_check(8'h5A, 1);
    frame = 0;
    drive(1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/maple_rx_decoders.md
Name: maple_rx_decoders

Overview:
Pattern and data decoding core of the Maple bus receiver. It consumes synchronised SDCKA/SDCKB levels and one-cycle edge strobes from the synchronizer. It contains three independent sub-decoders:
- start-pattern detector
- end-pattern detector
- byte assembler, enabled by the receiver's frame signal.

All outputs feed the receiver's frame FSM and byte sink.

Parameters:
START_NORMAL, 4, SDCKB falling edges in a normal start pattern
START_CRC, 6, SDCKB falling edges in a start-with-CRC pattern
START_OCC, 8, SDCKB falling edges in an occupancy start pattern
START_RST, 14, SDCKB falling edges in a reset start pattern
END_PULSES, 2, SDCKA falling edges in an end pattern

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  asynchronous, active-low
frame  in  1  high while the receiver is inside a frame; enables the byte assembler
sdcka_data  in  1  synchronised SDCKA level
sdcka_posedge  in  1  one-cycle strobe, SDCKA rose
sdcka_negedge  in  1  one-cycle strobe, SDCKA fell
sdckb_data  in  1  synchronised SDCKB level
sdckb_posedge  in  1  one-cycle strobe, SDCKB rose
sdckb_negedge  in  1  one-cycle strobe, SDCKB fell
start_frame  out  1  pulse: normal start detected
start_with_crc  out  1  pulse: CRC start detected
start_occupancy  out  1  pulse: occupancy start detected
start_reset  out  1  pulse: reset start detected
start_frame_error  out  1  pulse: malformed start
end_frame  out  1  pulse: end pattern detected
end_frame_error  out  1  pulse: malformed end
data  out  8  last assembled byte, MSB first
data_ready  out  1  pulse: data holds a new byte

Behaviour:
- Reset (reset=0, asynchronous): all detectors go IDLE, counters clear, every output is 0, data=8'h00.
- All pulse outputs are registered. Each is high for exactly one clk, in the cycle after the qualifying strobe.
- Same-cycle A and B strobes (any combination) are a glitch:
  - both pattern detectors return to IDLE with no output;
  - the byte assembler ignores both strobes.

Start detector (states IDLE, COUNT):
- IDLE -> COUNT on sdcka_negedge while sdckb_data=1; count cleared.
- COUNT: each sdckb_negedge increments the 4-bit count, saturating at 15.
- COUNT -> IDLE on sdcka_posedge, classifying the count:
  - 4 -> start_frame
  - 6 -> start_with_crc
  - 8 -> start_occupancy
  - 14 -> start_reset
  - 0 or 1 -> no output (normal data-bit activity)
  - any other value -> start_frame_error
- Exactly one start output fires per pattern.

End detector (states IDLE, COUNT):
- IDLE -> COUNT on sdckb_negedge while sdcka_data=1; count cleared.
- COUNT: each sdcka_negedge increments the count, saturating at 15.
- COUNT -> IDLE on sdckb_posedge:
  - count 2 -> end_frame
  - 0 or 1 -> no output (data activity)
  - >=3 -> end_frame_error
- Both detectors run regardless of frame.

Byte assembler:
- While frame=0: bit index held at 0; strobes ignored; data holds its value.
- While frame=1, bits alternate phases:
  - even bits (0,2,4,6) are sampled from sdckb_data on sdcka_negedge;
  - odd bits (1,3,5,7) are sampled from sdcka_data on sdckb_negedge.
  - A strobe of the wrong phase is ignored. This discards the trailing SDCKB fall of the start pattern.
- Bits shift in MSB first: bit 0 becomes data[7].
- On the 8th bit, the next cycle shows data = the full byte, data_ready=1 for one clk, and the index wraps to 0.
- data is stable until the next complete byte.
- frame dropping mid-byte: the partial byte is discarded, the index returns to 0, and data/data_ready are unaffected.
- Reset mid-byte: as global reset.

Test Plan:
- Idle lines: A fall, B 4 falling edges, A rise -> start_frame one 1-clk pulse; all other outputs 0. Repeat with 6/8/14 edges -> start_with_crc / start_occupancy / start_reset.
- A fall, B 5 falling edges, A rise -> start_frame_error only. With 1 B edge -> no output.
- B fall with A high, A 2 falling edges, B rise -> end_frame. With 3 A edges -> end_frame_error. With 1 A edge -> nothing.
- frame=1, send 0xA5 with alternating phases (A-clock bit=1, B-clock bit=0, ...) -> data=8'hA5 and data_ready one clk after the 8th edge. A preceding lone sdckb_negedge is ignored.
- frame=1, 4 bits sent, frame=0, frame=1, send 0x3C -> data=8'h3C; no data_ready for the partial byte.
- Reset asserted mid start-count and mid-byte -> outputs 0 immediately. The next clean 4-edge start gives start_frame.
